// File: rtl/memory_controller.sv
// memory_controller
//   Bridges the pipeline memory stage to a single-beat data-memory bus.
//   One load or store per request. Byte enables and lane-replicated write
//   data are formatted from the byte address and size. Loads are returned
//   sign- or zero-extended. The pipeline is stalled until the access
//   completes. Misaligned accesses and bus timeouts are reported as
//   one-cycle pulses.
// Ports
//   clk, rst                  clock, async active-low reset
//   read, write               request from memory stage (write wins)
//   memory_addr               byte address
//   data_to_write             right-justified store data
//   size, load_unsigned       00 byte / 01 half / 1x word, zero-extend select
//   read_data_from_memory_controller  registered extended load data
//   stall                     hold pipeline
//   misaligned_fault          pulse: access dropped
//   bus_error                 pulse: access timed out
//   bus_req/we/addr/be/wdata  bus request side, held stable while in REQ
//   bus_ack, bus_rdata        bus completion and read word
module memory_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] memory_addr,
  input  logic [31:0] data_to_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  output logic [31:0] read_data_from_memory_controller,
  output logic        stall,
  output logic        misaligned_fault,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  // Counter holds REQ cycles already spent; timeout fires on the cycle that
  // would make it reach TIMEOUT_CYCLES, so bus_req is high exactly that long.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        uns_q;
  logic [31:0] rdata_q;
  logic        mis_q, err_q, req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;

  logic        req_in, mis;
  logic [1:0]  off;
  logic [3:0]  be_fmt;
  logic [31:0] wd_fmt, shifted, ld_ext;

  assign req_in = read | write;
  assign off    = memory_addr[1:0];

  // Lane formatting and alignment check for the incoming request.
  always_comb begin
    mis    = 1'b0;
    be_fmt = 4'b0000;
    wd_fmt = '0;
    unique case (size)
      2'b00: begin
        be_fmt = 4'b0001 << off;
        wd_fmt = {4{data_to_write[7:0]}};
      end
      2'b01: begin
        mis    = off[0];
        be_fmt = 4'b0011 << {off[1], 1'b0};
        wd_fmt = {2{data_to_write[15:0]}};
      end
      default: begin
        mis    = |off;
        be_fmt = 4'b1111;
        wd_fmt = data_to_write;
      end
    endcase
  end

  // Load extraction from the latched offset/size.
  assign shifted = bus_rdata >> {off_q, 3'b000};
  always_comb begin
    ld_ext = shifted;
    unique case (size_q)
      2'b00:   ld_ext = uns_q ? {24'b0, shifted[7:0]}   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_ext = uns_q ? {16'b0, shifted[15:0]}  : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      mis_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_in) begin
            if (mis) begin
              mis_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= write;
              addr_q  <= {memory_addr[31:2], 2'b00};
              be_q    <= be_fmt;
              wdata_q <= wd_fmt;
              size_q  <= size;
              off_q   <= off;
              uns_q   <= load_unsigned;
              cnt_q   <= '0;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            if (!we_q) rdata_q <= ld_ext;
            state_q <= DONE;
          end else if (cnt_q == TO_LAST) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b1;
            if (!we_q) rdata_q <= '0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall asserts in the accepting IDLE cycle itself; faults never stall.
  assign stall = (state_q == REQ) || ((state_q == IDLE) && req_in && !mis);

  assign read_data_from_memory_controller = rdata_q;
  assign misaligned_fault = mis_q;
  assign bus_error        = err_q;
  assign bus_req          = req_q;
  assign bus_we           = we_q;
  assign bus_addr         = addr_q;
  assign bus_be           = be_q;
  assign bus_wdata        = wdata_q;

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Sits between the pipeline's memory stage and the external data-memory bus.
- Accepts one read or write request per instruction and performs it as a single-beat bus transaction with byte enables.
- Returns sign- or zero-extended load data and stalls the pipeline until the access completes.
- Detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, REQ-state cycles without bus_ack before the access is aborted (1..255).

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
read  input  1  load request from memory stage
write  input  1  store request from memory stage
memory_addr  input  32  byte address of access
data_to_write  input  32  store data, right-justified
size  input  2  00 byte, 01 half, 10 word; 11 treated as word
load_unsigned  input  1  1 = zero-extend load, 0 = sign-extend
read_data_from_memory_controller  output  32  extended load data, registered
stall  output  1  hold pipeline while high
misaligned_fault  output  1  one-cycle pulse, access dropped
bus_error  output  1  one-cycle pulse, access timed out
bus_req  output  1  bus request, held until ack
bus_we  output  1  1 = bus write
bus_addr  output  32  word-aligned address {addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_ack  input  1  transaction complete, single-cycle
bus_rdata  input  32  read word, valid when bus_ack=1

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0: read data, pulses, bus_req, bus_we, bus_addr, bus_be, bus_wdata. Timeout counter 0. Reset mid-transaction abandons the access with no completion pulse.
- States: IDLE, REQ, DONE.
- IDLE, no request (read=0, write=0): stall=0, remain.
- IDLE, request present:
  - Write has priority when read=1 and write=1.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned: misaligned_fault=1 next cycle for one cycle; no bus access; stall stays 0; go DONE.
  - Aligned: stall=1 combinationally this cycle. Latch addr, size, load_unsigned, we and the lane-formatted data. Go REQ.
- Lane formatting:
  - Byte: bus_be=4'b0001<<addr[1:0]; bus_wdata={4{d[7:0]}}.
  - Half: bus_be=4'b0011<<(2*addr[1]); bus_wdata={2{d[15:0]}}.
  - Word: bus_be=4'b1111; bus_wdata=d.
  - Reads drive the same bus_be.
- REQ:
  - bus_req=1; bus_we, bus_addr, bus_be and bus_wdata are held stable from registers; stall=1.
  - Counter increments each cycle.
  - bus_ack=1: for a read, capture bus_rdata>>(8*addr[1:0]), take the low byte/half/word, extend per the latched load_unsigned into read_data_from_memory_controller. Clear bus_req and counter; go DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: bus_error=1 for one cycle. For a read, read data=0. Clear bus_req; go DONE.
- DONE: stall=0 for exactly one cycle so the pipeline advances; request inputs ignored; go IDLE.
- Latency: with ack in the first REQ cycle, stall is high 2 cycles (IDLE, REQ) and data is valid in the DONE cycle.
- read_data_from_memory_controller holds its value until the next completed or timed-out read. Writes and faults do not change it.
- bus_ack outside REQ is ignored.

Test Plan:
- Word load: read=1, addr=0x100, size=10; bus_rdata=0xDEADBEEF with ack on the 1st REQ cycle -> bus_addr=0x100, bus_be=1111, stall high 2 cycles, read data=0xDEADBEEF in DONE.
- Signed/unsigned byte load: addr=0x103, bus_rdata=0x80112233 -> bus_be=1000; data=0xFFFFFF80 when load_unsigned=0, 0x00000080 when load_unsigned=1.
- Half store: write=1, addr=0x22, size=01, data=0x0000ABCD; ack after 3 wait cycles -> bus_we=1, bus_addr=0x20, bus_be=1100, bus_wdata=0xABCDABCD, all held stable 4 REQ cycles; stall high 5 cycles.
- Misaligned: word read at addr=0x102 -> misaligned_fault pulses once, bus_req never asserts, stall=0, read data unchanged.
- Timeout with TIMEOUT_CYCLES=4 and no ack -> bus_req high 4 cycles, then bus_error pulses once, read data=0, controller returns to IDLE and serves the next request normally.
- Reset in REQ: rst low mid-wait -> all outputs 0 immediately, state IDLE; a late bus_ack after reset release is ignored.
